// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared types and helpers for the multi-write-port register file.
//   - wr_src_e    : write sources in descending priority order
//   - resolve_src : picks the winning write source for one register address
package reg_file_pkg;

  // Enumeration order mirrors priority: load return beats ALU beats move.
  typedef enum logic [1:0] {
    SRC_LD   = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MOV  = 2'd2,
    SRC_NONE = 2'd3
  } wr_src_e;

  // Given which sources target a register this cycle, return the one that commits.
  function automatic wr_src_e resolve_src(input logic ld_hit,
                                          input logic alu_hit,
                                          input logic mov_hit);
    if (ld_hit)       return SRC_LD;
    else if (alu_hit) return SRC_ALU;
    else if (mov_hit) return SRC_MOV;
    else              return SRC_NONE;
  endfunction

endpackage

// File: rtl/reg_file_mp_pend_scoreboard.sv
// pend_scoreboard
//   One pending bit per register, tracking loads that have been issued but
//   whose data has not yet returned.
//   Ports:
//     Clk, Reset       : clock, synchronous active-high reset
//     pend_set_i       : mark pend_addr_i pending (load issued)
//     pend_addr_i      : register to mark
//     we_ld_i          : load return strobe, clears waddr_ld_i
//     waddr_ld_i       : load return address
//     pend_q_o         : current pending bits
//     pend_d_o         : pending bits as they will be after the next edge
//     pend_any_o       : OR of the current pending bits
module pend_scoreboard #(
  parameter int D       = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pend_set_i,
  input  logic [D-1:0]      pend_addr_i,
  input  logic              we_ld_i,
  input  logic [D-1:0]      waddr_ld_i,
  output logic [(1<<D)-1:0] pend_q_o,
  output logic [(1<<D)-1:0] pend_d_o,
  output logic              pend_any_o
);

  localparam int N = 1 << D;

  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;

  // Set wins over clear: a new load issued to the register whose previous
  // load is returning this cycle leaves it pending.
  always_comb begin
    pend_d = '0;
    for (int a = 0; a < N; a++) begin
      pend_d[a] = (pend_set_i && (pend_addr_i == D'(a))) ||
                  (pend_q[a] && !(we_ld_i && (waddr_ld_i == D'(a))));
      if (ZERO_R0 && (a == 0)) pend_d[a] = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pend_q_o   = pend_q;
  assign pend_d_o   = pend_d;
  assign pend_any_o = |pend_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
//   Multi-write-port register file with a pending-load scoreboard.
//   Write ports (priority per target address: load > ALU > move):
//     WeLd/WaddrLd/WdataLd     : load return, also clears the pending bit
//     WeAlu/WaddrAlu/WdataAlu  : ALU result
//     MovEn/MovSrc/MovDst      : copy stored MovSrc into MovDst
//   Read ports (combinational):
//     RaddrA/DataOutA/ValidA, RaddrB/DataOutB/ValidB
//   Scoreboard:
//     PendSet/PendAddr : mark a register pending when a load issues
//     PendAny          : some load is outstanding
//   Valid semantics: ValidX is a data-ready flag, not a handshake. ValidX = 0
//   means the register addressed by RaddrX awaits a load return; the consumer
//   must not use DataOutX then. There is no back-pressure, the file never stalls.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int W       = 8,
  parameter int D       = 4,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [D-1:0] RaddrA,
  input  logic [D-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  output logic         ValidA,
  output logic         ValidB,
  input  logic         WeAlu,
  input  logic [D-1:0] WaddrAlu,
  input  logic [W-1:0] WdataAlu,
  input  logic         WeLd,
  input  logic [D-1:0] WaddrLd,
  input  logic [W-1:0] WdataLd,
  input  logic         MovEn,
  input  logic [D-1:0] MovSrc,
  input  logic [D-1:0] MovDst,
  input  logic         PendSet,
  input  logic [D-1:0] PendAddr,
  output logic         PendAny
);

  localparam int N = 1 << D;

  logic [W-1:0] data_q [N];
  logic [W-1:0] data_d [N];
  logic [W-1:0] mov_data;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;

  // Move copies the stored value, never the value being written this cycle.
  assign mov_data = data_q[MovSrc];

  // Next-state per register. data_d doubles as the bypass source: for an
  // address with a writer it holds the winning data, otherwise the stored value.
  always_comb begin
    wr_src_e src;
    src = SRC_NONE;
    for (int a = 0; a < N; a++) begin
      data_d[a] = data_q[a];
      src = resolve_src(WeLd  && (WaddrLd  == D'(a)),
                        WeAlu && (WaddrAlu == D'(a)),
                        MovEn && (MovDst   == D'(a)) && (MovSrc != MovDst));
      if (ZERO_R0 && (a == 0)) src = SRC_NONE;
      case (src)
        SRC_LD:  data_d[a] = WdataLd;
        SRC_ALU: data_d[a] = WdataAlu;
        SRC_MOV: data_d[a] = mov_data;
        default: data_d[a] = data_q[a];
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int a = 0; a < N; a++) data_q[a] <= '0;
    end else begin
      for (int a = 0; a < N; a++) data_q[a] <= data_d[a];
    end
  end

  pend_scoreboard #(
    .D       (D),
    .ZERO_R0 (ZERO_R0)
  ) u_pend (
    .Clk         (Clk),
    .Reset       (Reset),
    .pend_set_i  (PendSet),
    .pend_addr_i (PendAddr),
    .we_ld_i     (WeLd),
    .waddr_ld_i  (WaddrLd),
    .pend_q_o    (pend_q),
    .pend_d_o    (pend_d),
    .pend_any_o  (PendAny)
  );

  // With ZERO_R0, data_q[0] is never written and pend bit 0 never set, so
  // register 0 naturally reads 0 / valid; the explicit checks keep it obvious.
  always_comb begin
    DataOutA = BYPASS ? data_d[RaddrA] : data_q[RaddrA];
    DataOutB = BYPASS ? data_d[RaddrB] : data_q[RaddrB];
    ValidA   = BYPASS ? !pend_d[RaddrA] : !pend_q[RaddrA];
    ValidB   = BYPASS ? !pend_d[RaddrB] : !pend_q[RaddrB];
    if (ZERO_R0 && (RaddrA == '0)) begin
      DataOutA = '0;
      ValidA   = 1'b1;
    end
    if (ZERO_R0 && (RaddrB == '0)) begin
      DataOutB = '0;
      ValidB   = 1'b1;
    end
  end

endmodule
